// File: rtl/cpu_regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the register bank.
package cpu_regfile_pkg;

    localparam int WIDTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks idx over all registers and emits a one-hot
// clear strobe, plus the registered write handshake and clear status.
module regfile_clr_seq
    import cpu_regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_req,
    output logic                wr_ready,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [NUM_REGS-1:0] clr_stb
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                wr_ready_q, wr_ready_d;
    logic                clr_busy_q, clr_busy_d;
    logic                clr_done_q, clr_done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == {ADDR_W{1'b1}}) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flops track the next state so they line up with state_q.
        wr_ready_d = (state_d == IDLE);
        clr_busy_d = (state_d != IDLE);
        clr_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wr_ready_q <= 1'b1;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ready_q <= wr_ready_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        clr_stb = '0;
        if (state_q == CLEAR) begin
            clr_stb[idx_q] = 1'b1;
        end
    end

    assign wr_ready = wr_ready_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: rtl/reg_file_bank.sv
// Sixteen-entry register bank with dirty mask and sequenced bulk clear.
// Define REGFILE_R0_ZERO_EN to hardwire r0 to zero.
module reg_file_bank
    import cpu_regfile_pkg::*;
#(
    parameter int WIDTH  = cpu_regfile_pkg::WIDTH,
    parameter int ADDR_W = cpu_regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [15:0]       dirty,
    output logic [WIDTH-1:0]  r0,
    output logic [WIDTH-1:0]  r1,
    output logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  r3,
    output logic [WIDTH-1:0]  r4,
    output logic [WIDTH-1:0]  r5,
    output logic [WIDTH-1:0]  r6,
    output logic [WIDTH-1:0]  r7,
    output logic [WIDTH-1:0]  r8,
    output logic [WIDTH-1:0]  r9,
    output logic [WIDTH-1:0]  r10,
    output logic [WIDTH-1:0]  r11,
    output logic [WIDTH-1:0]  r12,
    output logic [WIDTH-1:0]  r13,
    output logic [WIDTH-1:0]  r14,
    output logic [WIDTH-1:0]  r15
);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [NUM_REGS-1:0] clr_stb;

    regfile_clr_seq u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .wr_ready (wr_ready),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_stb  (clr_stb)
    );

    // Writes and clear strobes never overlap: wr_ready is low while clearing.
    always_comb begin
        regs_d  = regs_q;
        dirty_d = dirty_q;
        if (wr_en && wr_ready) begin
            regs_d[wr_addr]  = wr_data;
            dirty_d[wr_addr] = 1'b1;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_stb[i]) begin
                regs_d[i]  = '0;
                dirty_d[i] = 1'b0;
            end
        end
`ifdef REGFILE_R0_ZERO_EN
        regs_d[0]  = '0;
        dirty_d[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            dirty_q <= '0;
        end else begin
            regs_q  <= regs_d;
            dirty_q <= dirty_d;
        end
    end

    assign dirty = dirty_q;
    assign r0    = regs_q[0];
    assign r1    = regs_q[1];
    assign r2    = regs_q[2];
    assign r3    = regs_q[3];
    assign r4    = regs_q[4];
    assign r5    = regs_q[5];
    assign r6    = regs_q[6];
    assign r7    = regs_q[7];
    assign r8    = regs_q[8];
    assign r9    = regs_q[9];
    assign r10   = regs_q[10];
    assign r11   = regs_q[11];
    assign r12   = regs_q[12];
    assign r13   = regs_q[13];
    assign r14   = regs_q[14];
    assign r15   = regs_q[15];

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed self-checking bench for reg_file_bank.
module tb_reg_file_bank;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;
    logic [15:0] dirty;
    logic [15:0] r [16];

    logic [15:0] m [16];
    logic [15:0] md;
    int          n_chk;
    int          n_fail;

    reg_file_bank dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .dirty    (dirty),
        .r0       (r[0]),
        .r1       (r[1]),
        .r2       (r[2]),
        .r3       (r[3]),
        .r4       (r[4]),
        .r5       (r[5]),
        .r6       (r[6]),
        .r7       (r[7]),
        .r8       (r[8]),
        .r9       (r[9]),
        .r10      (r[10]),
        .r11      (r[11]),
        .r12      (r[12]),
        .r13      (r[13]),
        .r14      (r[14]),
        .r15      (r[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m[i] = 16'h0;
        md = 16'h0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] d);
`ifdef REGFILE_R0_ZERO_EN
        if (a == 4'd0) return;
`endif
        m[a]  = d;
        md[a] = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_write(a, d);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_r%0d", tag, i), {16'h0, r[i]}, {16'h0, m[i]});
        end
        chk({tag, "_dirty"}, {16'h0, dirty}, {16'h0, md});
    endtask

    task automatic check_ctl(input string tag, input logic rdy,
                             input logic bsy, input logic dn);
        chk({tag, "_wr_ready"}, {31'h0, wr_ready}, {31'h0, rdy});
        chk({tag, "_clr_busy"}, {31'h0, clr_busy}, {31'h0, bsy});
        chk({tag, "_clr_done"}, {31'h0, clr_done}, {31'h0, dn});
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 16'h0;
        clr_req = 1'b0;
        model_clear();
        tick();
        tick();
        check_all("rst");
        check_ctl("rst", 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        do_write(4'd5, 16'hBEEF);
        chk("beef_r5", {16'h0, r[5]}, 32'h0000_BEEF);
        chk("beef_dirty", {16'h0, dirty}, 32'h0000_0020);
        check_all("beef");
        check_ctl("beef", 1'b1, 1'b0, 1'b0);

        do_write(4'd3, 16'h1234);
        wr_en   = 1'b1;
        wr_data = 16'h5678;
        chk("nobypass_r3", {16'h0, r[3]}, 32'h0000_1234);
        tick();
        wr_en = 1'b0;
        model_write(4'd3, 16'h5678);
        chk("b2b_r3", {16'h0, r[3]}, 32'h0000_5678);
        chk("b2b_dirty3", {31'h0, dirty[3]}, 32'h1);

        for (int n = 0; n < 16; n++) begin
            do_write(n[3:0], 16'h0100 + n[15:0]);
        end
        check_all("fill");
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check_ctl("clr_start", 1'b0, 1'b1, 1'b0);
        wr_en   = 1'b1;
        wr_data = 16'hDEAD;
        for (int k = 0; k < 16; k++) begin
            wr_addr = 4'd15 - k[3:0];
            tick();
            m[k]  = 16'h0;
            md[k] = 1'b0;
            check_all($sformatf("clr%0d", k));
            chk($sformatf("clr%0d_done", k), {31'h0, clr_done},
                {31'h0, (k == 15)});
            chk($sformatf("clr%0d_busy", k), {31'h0, clr_busy}, 32'h1);
        end
        wr_en = 1'b0;
        tick();
        check_ctl("clr_end", 1'b1, 1'b0, 1'b0);
        check_all("clr_end");

        do_write(4'd4, 16'h0444);
        wr_en   = 1'b1;
        wr_addr = 4'd15;
        wr_data = 16'hAAAA;
        clr_req = 1'b1;
        tick();
        wr_en   = 1'b0;
        clr_req = 1'b0;
        model_write(4'd15, 16'hAAAA);
        chk("aaaa_r15", {16'h0, r[15]}, 32'h0000_AAAA);
        chk("aaaa_dirty", {16'h0, dirty}, 32'h0000_8010);
        for (int k = 0; k < 16; k++) tick();
        model_clear();
        chk("aaaa_done", {31'h0, clr_done}, 32'h1);
        check_all("aaaa_end");
        tick();
        check_ctl("aaaa_idle", 1'b1, 1'b0, 1'b0);

        do_write(4'd7, 16'h0777);
        do_write(4'd9, 16'h0999);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("mid_r9", {16'h0, r[9]}, 32'h0000_0999);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all("midrst");
        check_ctl("midrst", 1'b1, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        do_write(4'd2, 16'h0042);
        chk("post_r2", {16'h0, r[2]}, 32'h0000_0042);
        chk("post_dirty", {16'h0, dirty}, 32'h0000_0004);
        check_ctl("post", 1'b1, 1'b0, 1'b0);

        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'hFFFF;
        #1;
        chk("r0w_ready", {31'h0, wr_ready}, 32'h1);
        tick();
        wr_en = 1'b0;
        model_write(4'd0, 16'hFFFF);
`ifdef REGFILE_R0_ZERO_EN
        chk("r0w_r0", {16'h0, r[0]}, 32'h0);
        chk("r0w_dirty0", {31'h0, dirty[0]}, 32'h0);
`else
        chk("r0w_r0", {16'h0, r[0]}, 32'h0000_FFFF);
        chk("r0w_dirty0", {31'h0, dirty[0]}, 32'h1);
`endif
        check_all("r0w");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
